// File: rtl/y86_fetch_seq_if.sv
// ---------------------------------------------------------------------------
// y86_fetch_seq_if
//
// Bundles every non-clock, non-reset signal of the Y86 fetch sequencer.
//
//   Instruction-memory byte bus
//     mem_req       sequencer -> memory  byte read request
//     mem_addr[63:0] sequencer -> memory byte address, stable until mem_ack
//     mem_ack       memory -> sequencer  read complete, mem_rdata valid
//     mem_rdata[7:0] memory -> sequencer returned instruction byte
//
//   Decoded-instruction handshake (towards decode/execute)
//     instr_valid   decoded fields below are valid
//     instr_ready   consumer accepts the instruction
//     icode, ifun, rA, rB, valC, valP, instr_invalid, imem_error
//
//   PC loop / status
//     next_pc, pc_load  next PC returned by the PC-update stage
//     pc                architectural PC register
//     halted            sequencer stopped (only reset exits)
//
// Modports: master = the fetch sequencer, slave = its environment.
// ---------------------------------------------------------------------------
interface y86_fetch_seq_if;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        instr_invalid;
    logic        imem_error;

    logic [63:0] next_pc;
    logic        pc_load;
    logic [63:0] pc;
    logic        halted;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
        output instr_valid, icode, ifun, rA, rB, valC, valP,
        output instr_invalid, imem_error,
        input  instr_ready,
        input  next_pc, pc_load,
        output pc, halted
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
        input  instr_valid, icode, ifun, rA, rB, valC, valP,
        input  instr_invalid, imem_error,
        output instr_ready,
        output next_pc, pc_load,
        input  pc, halted
    );
endinterface

// File: rtl/y86_fetch_seq.sv
// ---------------------------------------------------------------------------
// y86_fetch_seq
//
// Fetch sequencer for a sequential Y86-64 core. Owns the architectural PC,
// reads the current instruction one byte at a time over a req/ack byte bus,
// splits it into icode/ifun/rA/rB/valC, computes valP and presents the
// result on a valid/ready handshake. It then waits for the PC-update stage
// to return the next PC on pc_load before fetching again.
//
// Ports
//   clk   core clock, all state updates on the rising edge
//   rst   asynchronous active-high reset
//   bus   y86_fetch_seq_if.master (memory bus, decoded outputs, pc loop)
//
// Parameters
//   START_PC   PC value loaded on reset
//   IMEM_SIZE  instruction memory size in bytes (bound check only)
//
// Optional feature
//   `define IMEM_BOUND_CHECK_EN : before every byte request the address is
//   compared against IMEM_SIZE. An out-of-range address issues no request;
//   the partial instruction is presented with imem_error=1 and the sequencer
//   halts after the handshake. Without the macro imem_error is constant 0 and
//   addresses wrap modulo 2^64.
//
// Timing: every byte costs at least two cycles, because mem_req is dropped
// for one cycle after each mem_ack before the next request is raised.
// ---------------------------------------------------------------------------
module y86_fetch_seq #(
    parameter logic [63:0] START_PC  = 64'h0,
    parameter logic [63:0] IMEM_SIZE = 64'h1000
) (
    input logic            clk,
    input logic            rst,
    y86_fetch_seq_if.master bus
);

    typedef enum logic [1:0] {
        FETCH,
        PRESENT,
        WAIT_PC,
        HALTED
    } state_t;

    // Instruction length in bytes, derived from icode alone.
    function automatic logic [3:0] instr_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       instr_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
            4'h7, 4'h8:             instr_len = 4'd9;
            4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
            default:                instr_len = 4'd1;  // invalid icode
        endcase
    endfunction

    // Byte 1 is a register specifier byte for these icodes.
    function automatic logic has_regs(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_regs = 1'b1;
            default:                                  has_regs = 1'b0;
        endcase
    endfunction

    state_t      state;
    logic [3:0]  count;       // bytes captured so far for this instruction
    logic [63:0] pc_q;
    logic        mem_req_q;
    logic [63:0] mem_addr_q;
    logic        instr_valid_q;
    logic [3:0]  icode_q;
    logic [3:0]  ifun_q;
    logic [3:0]  ra_q;
    logic [3:0]  rb_q;
    logic [63:0] valc_q;
    logic [63:0] valp_q;
    logic        invalid_q;
    logic        imem_error_q;
    logic        halted_q;

    // ------------------------------------------------------------------
    // Combinational helpers for the byte being returned this cycle
    // ------------------------------------------------------------------
    logic [63:0] fetch_addr;
    logic        first_byte;
    logic [3:0]  cur_icode;
    logic [3:0]  cur_len;
    logic        last_byte;
    logic        valc_byte;
    logic [2:0]  valc_idx;
    logic        bound_hit;

    assign fetch_addr = pc_q + {60'd0, count};
    assign first_byte = (count == 4'd0);
    // On byte 0 the icode register still holds the previous instruction,
    // so the length must come straight from the returned byte.
    assign cur_icode  = first_byte ? bus.mem_rdata[7:4] : icode_q;
    assign cur_len    = instr_len(cur_icode);
    assign last_byte  = ((count + 4'd1) == cur_len);

    // Which valC byte lane (if any) the current byte fills. valC is
    // little-endian: lane 0 is the first constant byte fetched.
    // NOTE: every signal written in always_comb gets a default first;
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        valc_byte = 1'b0;
        valc_idx  = 3'd0;
        if (!first_byte) begin
            case (icode_q)
                4'h7, 4'h8: begin
                    valc_byte = 1'b1;
                    valc_idx  = 3'(count - 4'd1);
                end
                4'h3, 4'h4, 4'h5: begin
                    valc_byte = (count >= 4'd2);
                    valc_idx  = 3'(count - 4'd2);
                end
                default: ;
            endcase
        end
    end

`ifdef IMEM_BOUND_CHECK_EN
    assign bound_hit = (fetch_addr >= IMEM_SIZE);
`else
    // IMEM_SIZE only matters to the bound check; fold it into a sink so the
    // default build carries no dangling parameter.
    logic unused_imem_size;
    assign unused_imem_size = ^IMEM_SIZE;
    assign bound_hit        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FETCH;
            count         <= 4'd0;
            pc_q          <= START_PC;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 64'd0;
            instr_valid_q <= 1'b0;
            icode_q       <= 4'h0;
            ifun_q        <= 4'h0;
            ra_q          <= 4'hF;
            rb_q          <= 4'hF;
            valc_q        <= 64'd0;
            valp_q        <= 64'd0;
            invalid_q     <= 1'b0;
            imem_error_q  <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_req_q) begin
                        // Request outstanding: address held until ack.
                        if (bus.mem_ack) begin
                            mem_req_q <= 1'b0;
                            count     <= count + 4'd1;
                            if (first_byte) begin
                                icode_q   <= bus.mem_rdata[7:4];
                                ifun_q    <= bus.mem_rdata[3:0];
                                ra_q      <= 4'hF;
                                rb_q      <= 4'hF;
                                valc_q    <= 64'd0;
                                invalid_q <= (bus.mem_rdata[7:4] > 4'hB);
                            end else if (count == 4'd1 && has_regs(icode_q)) begin
                                ra_q <= bus.mem_rdata[7:4];
                                rb_q <= bus.mem_rdata[3:0];
                            end
                            if (valc_byte) begin
                                valc_q <= valc_q | ({56'd0, bus.mem_rdata} << {valc_idx, 3'b000});
                            end
                            if (last_byte) begin
                                instr_valid_q <= 1'b1;
                                valp_q        <= pc_q + {60'd0, cur_len};
                                state         <= PRESENT;
                            end
                        end
                    end else if (bound_hit) begin
                        // Present whatever was fetched so far and stop.
                        if (first_byte) begin
                            icode_q   <= 4'h0;
                            ifun_q    <= 4'h0;
                            ra_q      <= 4'hF;
                            rb_q      <= 4'hF;
                            valc_q    <= 64'd0;
                            invalid_q <= 1'b0;
                        end
                        imem_error_q  <= 1'b1;
                        instr_valid_q <= 1'b1;
                        valp_q        <= fetch_addr;
                        state         <= PRESENT;
                    end else begin
                        // Idle or post-ack gap cycle: raise the next request.
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_addr;
                    end
                end

                PRESENT: begin
                    if (bus.instr_ready) begin
                        instr_valid_q <= 1'b0;
                        if (icode_q == 4'h0 || invalid_q || imem_error_q) begin
                            halted_q <= 1'b1;
                            state    <= HALTED;
                        end else if (bus.pc_load) begin
                            // PC-update answered in the same cycle: skip WAIT_PC.
                            pc_q  <= bus.next_pc;
                            count <= 4'd0;
                            state <= FETCH;
                        end else begin
                            state <= WAIT_PC;
                        end
                    end
                end

                WAIT_PC: begin
                    if (bus.pc_load) begin
                        pc_q  <= bus.next_pc;
                        count <= 4'd0;
                        state <= FETCH;
                    end
                end

                HALTED: begin
                    // Terminal until reset; pc_load is ignored here.
                end
            endcase
        end
    end

    assign bus.mem_req       = mem_req_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.instr_valid   = instr_valid_q;
    assign bus.icode         = icode_q;
    assign bus.ifun          = ifun_q;
    assign bus.rA            = ra_q;
    assign bus.rB            = rb_q;
    assign bus.valC          = valc_q;
    assign bus.valP          = valp_q;
    assign bus.instr_invalid = invalid_q;
    assign bus.imem_error    = imem_error_q;
    assign bus.pc            = pc_q;
    assign bus.halted        = halted_q;

endmodule

// File: tb/tb_y86_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_y86_fetch_seq
//
// Directed bench for y86_fetch_seq (default build, START_PC=0). A byte
// memory model answers requests on the falling edge with a programmable
// latency and logs every request address. A table of instruction vectors
// is fetched one by one; hand-written sequences cover consumer stall,
// same-cycle pc_load, pc_load while halted and reset during a fetch.
// ---------------------------------------------------------------------------
module tb_y86_fetch_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    y86_fetch_seq_if bus ();

    y86_fetch_seq #(
        .START_PC  (64'h0),
        .IMEM_SIZE (64'h1000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int tests  = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Byte memory model (512 bytes, address bits [8:0])
    // ------------------------------------------------------------------
    logic [7:0]  mem [512];
    logic [63:0] addr_log [$];
    int          lat       = 1;
    int          ack_limit = 1000000;
    int          acks_given = 0;
    int          wait_cnt  = 0;
    bit          logged    = 1'b0;

    always @(negedge clk) begin
        bus.mem_ack = 1'b0;
        if (bus.mem_req && !rst) begin
            if (!logged) begin
                addr_log.push_back(bus.mem_addr);
                logged = 1'b1;
            end
            if (acks_given < ack_limit && wait_cnt >= lat) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr[8:0]];
                acks_given++;
                wait_cnt = 0;
                logged   = 1'b0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            logged   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [63:0] pc;
        logic [79:0] bytes;   // right-aligned, byte 0 is the most significant used byte
        int          len;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic        inv;
    } vec_t;

    vec_t vecs [12];

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    endtask

    task automatic load_bytes(input logic [63:0] pc, input logic [79:0] bytes, input int len);
        for (int k = 0; k < len; k++) begin
            logic [63:0] a;
            a = pc + 64'(k);
            mem[a[8:0]] = bytes[8*(len-1-k) +: 8];
        end
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.instr_ready = 1'b0;
        bus.pc_load     = 1'b0;
        bus.next_pc     = 64'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus.instr_valid && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " instr_valid"}, 64'(bus.instr_valid), 64'd1);
    endtask

    task automatic accept(input logic load, input logic [63:0] npc);
        @(negedge clk);
        bus.instr_ready = 1'b1;
        bus.pc_load     = load;
        bus.next_pc     = npc;
        @(posedge clk);
        #1;
        bus.instr_ready = 1'b0;
        bus.pc_load     = 1'b0;
    endtask

    // Reset, then steer the PC to 'pc' by fetching a nop at address 0 and
    // returning 'pc' on pc_load. Returns the log index where the target
    // fetch begins.
    task automatic goto_pc(input logic [63:0] pc, output int base);
        do_reset();
        base = addr_log.size();
        if (pc != 64'd0) begin
            wait_valid("preamble");
            check("preamble icode", 64'(bus.icode), 64'h1);
            accept(1'b1, pc);
            base = addr_log.size();
        end
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int base;

        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = 8'h00;
        bus.instr_ready = 1'b0;
        bus.pc_load     = 1'b0;
        bus.next_pc     = 64'd0;

        //          pc                      bytes                               len icode ifun rA    rB    valC                    valP                    inv
        vecs[0]  = '{64'h0,    80'h30_F3_88_77_66_55_44_33_22_11, 10, 4'h3, 4'h0, 4'hF, 4'h3, 64'h1122334455667788, 64'hA,   1'b0};
        vecs[1]  = '{64'h100,  80'h60_23,                          2, 4'h6, 4'h0, 4'h2, 4'h3, 64'h0,                64'h102, 1'b0};
        vecs[2]  = '{64'h20,   80'h73_40_00_00_00_00_00_00_00,     9, 4'h7, 4'h3, 4'hF, 4'hF, 64'h40,               64'h29,  1'b0};
        vecs[3]  = '{64'h8,    80'h00,                             1, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0,                64'h9,   1'b0};
        vecs[4]  = '{64'h30,   80'hE0,                             1, 4'hE, 4'h0, 4'hF, 4'hF, 64'h0,                64'h31,  1'b1};
        vecs[5]  = '{64'h50,   80'h10,                             1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,                64'h51,  1'b0};
        vecs[6]  = '{64'h60,   80'h20_45,                          2, 4'h2, 4'h0, 4'h4, 4'h5, 64'h0,                64'h62,  1'b0};
        vecs[7]  = '{64'h70,   80'h80_EF_BE_AD_DE_00_00_00_00,     9, 4'h8, 4'h0, 4'hF, 4'hF, 64'hDEADBEEF,         64'h79,  1'b0};
        vecs[8]  = '{64'h80,   80'hA0_6F,                          2, 4'hA, 4'h0, 4'h6, 4'hF, 64'h0,                64'h82,  1'b0};
        vecs[9]  = '{64'h90,   80'h50_12_08_00_00_00_00_00_00_00, 10, 4'h5, 4'h0, 4'h1, 4'h2, 64'h8,                64'h9A,  1'b0};
        vecs[10] = '{64'hB0,   80'h40_37_FF_FF_FF_FF_FF_FF_FF_FF, 10, 4'h4, 4'h0, 4'h3, 4'h7, 64'hFFFFFFFFFFFFFFFF, 64'hBA,  1'b0};
        // Wraps past 2^64: byte 1 (0x10) lands on address 0, where it also
        // serves as the nop of the preamble fetch.
        vecs[11] = '{64'hFFFFFFFFFFFFFFFF, 80'h61_10,              2, 4'h6, 4'h1, 4'h1, 4'h0, 64'h0,                64'h1,   1'b0};

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("reset mem_req",     64'(bus.mem_req), 64'd0);
        check("reset instr_valid", 64'(bus.instr_valid), 64'd0);
        check("reset pc",          bus.pc, 64'h0);
        check("reset rA/rB",       64'({bus.rA, bus.rB}), 64'hFF);
        check("reset icode/ifun",  64'({bus.icode, bus.ifun}), 64'h0);
        check("reset valC/valP",   bus.valC | bus.valP, 64'h0);
        check("reset flags",       64'({bus.instr_invalid, bus.imem_error, bus.halted}), 64'd0);

        // ---- table-driven vectors ----
        for (int i = 0; i < 12; i++) begin
            vec_t v;
            v   = vecs[i];
            lat = i % 3;
            clear_mem();
            mem[0] = 8'h10;
            load_bytes(v.pc, v.bytes, v.len);
            goto_pc(v.pc, base);
            wait_valid($sformatf("v%0d", i));
            check($sformatf("v%0d icode", i), 64'(bus.icode), 64'(v.icode));
            check($sformatf("v%0d ifun", i),  64'(bus.ifun),  64'(v.ifun));
            check($sformatf("v%0d rA", i),    64'(bus.rA),    64'(v.ra));
            check($sformatf("v%0d rB", i),    64'(bus.rB),    64'(v.rb));
            check($sformatf("v%0d valC", i),  bus.valC,       v.valc);
            check($sformatf("v%0d valP", i),  bus.valP,       v.valp);
            check($sformatf("v%0d invalid", i), 64'(bus.instr_invalid), 64'(v.inv));
            check($sformatf("v%0d nreq", i), 64'(addr_log.size() - base), 64'(v.len));
            for (int k = 0; k < v.len && base + k < addr_log.size(); k++)
                check($sformatf("v%0d addr%0d", i, k), addr_log[base + k], v.pc + 64'(k));

            accept(1'b0, 64'd0);
            check($sformatf("v%0d valid drop", i), 64'(bus.instr_valid), 64'd0);
            if (v.icode == 4'h0 || v.inv) begin
                check($sformatf("v%0d halted", i), 64'(bus.halted), 64'd1);
                // pc_load must be ignored once halted
                @(negedge clk);
                bus.pc_load = 1'b1;
                bus.next_pc = 64'h40;
                @(negedge clk);
                bus.pc_load = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                check($sformatf("v%0d halted pc", i), bus.pc, v.pc);
                check($sformatf("v%0d halted req", i), 64'({bus.mem_req, bus.instr_valid, bus.halted}), 64'b001);
            end else begin
                // WAIT_PC: no fetch until pc_load
                repeat (3) @(posedge clk);
                #1;
                check($sformatf("v%0d wait_pc idle", i), 64'({bus.mem_req, bus.halted}), 64'd0);
            end
        end

        // ---- consumer stall at 0x100, then pc_load to 0x102 ----
        lat = 1;
        clear_mem();
        mem[0] = 8'h10;
        load_bytes(64'h100, 80'h60_23, 2);
        mem[9'h102] = 8'h10;
        goto_pc(64'h100, base);
        wait_valid("stall");
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall hold c%0d", c),
                  {bus.valP[31:0], 15'd0, bus.instr_valid, bus.icode, bus.ifun, bus.rA, bus.rB},
                  {32'h102, 15'd0, 1'b1, 4'h6, 4'h0, 4'h2, 4'h3});
        end
        accept(1'b0, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("stall wait_pc req", 64'(bus.mem_req), 64'd0);
        base = addr_log.size();
        @(negedge clk);
        bus.pc_load = 1'b1;
        bus.next_pc = 64'h102;
        @(negedge clk);
        bus.pc_load = 1'b0;
        wait_valid("after 0x102");
        check("after 0x102 first addr", (addr_log.size() > base) ? addr_log[base] : 64'hX, 64'h102);
        check("after 0x102 pc", bus.pc, 64'h102);

        // ---- jXX at 0x20, instr_ready and pc_load in the same cycle ----
        clear_mem();
        mem[0] = 8'h10;
        load_bytes(64'h20, 80'h73_40_00_00_00_00_00_00_00, 9);
        goto_pc(64'h20, base);
        wait_valid("same-cycle");
        accept(1'b1, 64'h40);
        check("same-cycle pc", bus.pc, 64'h40);
        check("same-cycle gap", 64'(bus.mem_req), 64'd0);
        @(posedge clk);
        #1;
        check("same-cycle req", 64'(bus.mem_req), 64'd1);
        check("same-cycle addr", bus.mem_addr, 64'h40);

        // ---- reset while the 4th byte is outstanding ----
        lat = 0;
        clear_mem();
        load_bytes(64'h0, 80'h30_F3_88_77_66_55_44_33_22_11, 10);
        do_reset();
        base = addr_log.size();
        ack_limit = acks_given + 3;
        for (int n = 0; n < 100 && addr_log.size() < base + 4; n++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("midreset req before", 64'(bus.mem_req), 64'd1);
        check("midreset addr before", bus.mem_addr, 64'h3);
        #2;
        rst = 1'b1;
        #1;
        check("midreset req", 64'(bus.mem_req), 64'd0);
        check("midreset pc", bus.pc, 64'h0);
        ack_limit = 1000000;
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        base = addr_log.size();
        wait_valid("refetch");
        check("refetch first addr", (addr_log.size() > base) ? addr_log[base] : 64'hX, 64'h0);
        check("refetch nreq", 64'(addr_log.size() - base), 64'd10);
        check("refetch valC", bus.valC, 64'h1122334455667788);
        check("refetch valP", bus.valP, 64'hA);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
